// File: rtl/audio_fetch_arbiter_pkg.sv
// Shared types and constants for the audio sample-delta fetch arbiter.
// Holds the fetch FSM state encoding and the channel-index width helper.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W     = 12;
    localparam int AUDIO_MAX_CHANNELS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } FetchState;

    // A single-channel build still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/audio_fetch_arbiter_if.sv
// Bundle of channel-side and memory-side signals around the fetch arbiter.
// The arbiter uses the slave view; the environment uses the master view.
interface audio_fetch_arbiter_if
    import audio_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = AUDIO_SAMPLE_W
);
    logic [CHANNELS-1:0]        i_req;
    logic [CHANNELS*ADDR_W-1:0] i_addr;
    logic [CHANNELS-1:0]        o_ack;
    logic [DATA_W-1:0]          o_data;
    logic [ADDR_W-1:0]          o_memAddr;
    logic                       o_memRead;
    logic [DATA_W-1:0]          i_memData;
    logic                       i_frameStart;
    logic [CHANNELS-1:0]        i_clearUnderrun;
    logic [CHANNELS-1:0]        o_underrun;

    modport slave (
        input  i_req, i_addr, i_memData, i_frameStart, i_clearUnderrun,
        output o_ack, o_data, o_memAddr, o_memRead, o_underrun
    );

    modport master (
        output i_req, i_addr, i_memData, i_frameStart, i_clearUnderrun,
        input  o_ack, o_data, o_memAddr, o_memRead, o_underrun
    );
endinterface

// File: rtl/audio_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Rotates the request vector so the search is a plain lowest-set-bit scan.
module audio_rr_picker
    import audio_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int IDX_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic                valid,
    output logic [IDX_W-1:0]    grant
);
    logic [CHANNELS-1:0]            rot;
    logic [CHANNELS:0]              seen;
    logic [CHANNELS:0][IDX_W-1:0]   offs;
    logic [IDX_W:0]                 sum;

    assign rot     = CHANNELS'({req, req} >> ptr);
    assign seen[0] = 1'b0;
    assign offs[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_scan
            assign seen[gi+1] = seen[gi] | rot[gi];
            assign offs[gi+1] = offs[gi] | ((rot[gi] && !seen[gi]) ? IDX_W'(gi) : '0);
        end
    endgenerate

    assign valid = seen[CHANNELS];
    assign sum   = {1'b0, ptr} + {1'b0, offs[CHANNELS]};
    // Offset is relative to ptr, so fold the sum back into the channel range.
    assign grant = (sum >= (IDX_W+1)'(CHANNELS)) ? IDX_W'(sum - (IDX_W+1)'(CHANNELS))
                                                 : sum[IDX_W-1:0];
endmodule

// File: rtl/audio_fetch_arbiter.sv
// Round-robin arbiter sharing one sample-delta memory read port between channels,
// with per-channel sticky underrun flags evaluated at each frame boundary.
module audio_fetch_arbiter
    import audio_pkg::*;
#(
    parameter int CHANNELS    = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = AUDIO_SAMPLE_W,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    audio_fetch_arbiter_if.slave  bus
);
    localparam int IDX_W = idx_width(CHANNELS);
    localparam int CNT_W = 3;

    FetchState              state_reg, state_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    logic [IDX_W-1:0]       grant_reg, grant_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [CHANNELS-1:0]    ack_reg, ack_next;
    logic [CHANNELS-1:0]    underrun_reg, underrun_next;
    logic [DATA_W-1:0]      data_reg, data_next;
    logic [ADDR_W-1:0]      mem_addr_reg, mem_addr_next;
    logic                   mem_read_reg, mem_read_next;

    logic [ADDR_W-1:0]      addr_arr [CHANNELS];
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_grant;
    logic [CHANNELS-1:0]    grant_onehot;
    logic                   busy;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_addr
            assign addr_arr[gi] = bus.i_addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    audio_rr_picker #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req   (bus.i_req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .grant (pick_grant)
    );

    assign grant_onehot = CHANNELS'(1) << grant_reg;
    assign busy         = (state_reg != IDLE);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        grant_next    = grant_reg;
        cnt_next      = cnt_reg;
        ack_next      = '0;
        data_next     = data_reg;
        mem_addr_next = mem_addr_reg;
        mem_read_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next    = pick_grant;
                    mem_addr_next = addr_arr[pick_grant];
                    mem_read_next = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = CNT_W'(MEM_LATENCY);
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == CNT_W'(1)) begin
                    data_next  = bus.i_memData;
                    ack_next   = grant_onehot;
                    cnt_next   = '0;
                    state_next = RESPOND;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESPOND: begin
                ptr_next   = (grant_reg == IDX_W'(CHANNELS - 1)) ? '0 : grant_reg + IDX_W'(1);
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // The channel being served is not starving, so it never flags itself.
        underrun_next = (underrun_reg & ~bus.i_clearUnderrun)
                      | (bus.i_frameStart ? (bus.i_req & ~(busy ? grant_onehot : '0)) : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_reg    <= '0;
            cnt_reg      <= '0;
            ack_reg      <= '0;
            underrun_reg <= '0;
            data_reg     <= '0;
            mem_addr_reg <= '0;
            mem_read_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            grant_reg    <= grant_next;
            cnt_reg      <= cnt_next;
            ack_reg      <= ack_next;
            underrun_reg <= underrun_next;
            data_reg     <= data_next;
            mem_addr_reg <= mem_addr_next;
            mem_read_reg <= mem_read_next;
        end
    end

    assign bus.o_ack      = ack_reg;
    assign bus.o_data     = data_reg;
    assign bus.o_memAddr  = mem_addr_reg;
    assign bus.o_memRead  = mem_read_reg;
    assign bus.o_underrun = underrun_reg;
endmodule

// File: tb/tb_audio_fetch_arbiter.sv
// Bench for audio_fetch_arbiter: two instances (memory latency 1 and 3) driven by
// directed phases and a random phase, checked against a transaction-timeline model.
module tb_audio_fetch_arbiter;
    import audio_pkg::*;

    localparam int N  = 8;
    localparam int AW = 32;
    localparam int DW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    audio_fetch_arbiter_if #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW)) bus0 ();
    audio_fetch_arbiter_if #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW)) bus1 ();

    audio_fetch_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0.slave));
    audio_fetch_arbiter #(.CHANNELS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1.slave));

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Stimulus state
    logic [N-1:0]  req [2];
    logic [AW-1:0] addr [N];
    logic          frame, frame_s, rst_s, prev_rst;
    logic [N-1:0]  clear, clear_s;
    bit            rnd_mode;

    // Reference model: one in-flight transaction per instance, timed by cycle number
    int            lat [2] = '{1, 3};
    bit            active [2];
    int            strobe_c [2], ack_c [2], ch [2], busy_lo [2], busy_hi [2], next_arb [2], ptr [2];
    logic [AW-1:0] exp_addr [2];
    logic [DW-1:0] exp_data [2], last_data [2];
    logic [N-1:0]  exp_under [2];

    // Memory model and observations
    bit            mem_pend [2];
    int            mem_due [2];
    logic [DW-1:0] mem_val [2];
    logic [N-1:0]  o_ack [2], o_under [2];
    logic [DW-1:0] o_data [2];
    logic [AW-1:0] o_maddr [2];
    logic          o_mread [2];
    int            obs_ack_c [2], obs_ack_ch [2], obs_strobe_c [2];
    int            ackq [$];
    int            ackc [$];
    int            t_raise;

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a[11:0] ^ a[23:12] ^ 12'h3C1;
    endfunction

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            active[d]    = 0;
            ptr[d]       = 0;
            exp_under[d] = '0;
            last_data[d] = '0;
            busy_lo[d]   = -1;
            busy_hi[d]   = -1;
            ch[d]        = 0;
            next_arb[d]  = cyc + 1;
        end
    endtask

    task automatic step();
        logic [N-1:0] ea;
        logic [N-1:0] set;
        int g;
        @(negedge clk);
        cyc++;
        o_ack[0] = bus0.o_ack;   o_data[0] = bus0.o_data;   o_maddr[0] = bus0.o_memAddr;
        o_mread[0] = bus0.o_memRead;   o_under[0] = bus0.o_underrun;
        o_ack[1] = bus1.o_ack;   o_data[1] = bus1.o_data;   o_maddr[1] = bus1.o_memAddr;
        o_mread[1] = bus1.o_memRead;   o_under[1] = bus1.o_underrun;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("memRead d%0d c%0d", d, cyc), 64'(o_mread[d]),
                64'(active[d] && cyc == strobe_c[d]));
            if (active[d] && cyc == strobe_c[d])
                chk($sformatf("memAddr d%0d c%0d", d, cyc), 64'(o_maddr[d]), 64'(exp_addr[d]));
            ea = (active[d] && cyc == ack_c[d]) ? (N'(1) << ch[d]) : '0;
            chk($sformatf("ack d%0d c%0d", d, cyc), 64'(o_ack[d]), 64'(ea));
            if (ea != '0) begin
                last_data[d] = exp_data[d];
                active[d]    = 0;
            end
            chk($sformatf("data d%0d c%0d", d, cyc), 64'(o_data[d]), 64'(last_data[d]));
            chk($sformatf("underrun d%0d c%0d", d, cyc), 64'(o_under[d]), 64'(exp_under[d]));
            if (o_ack[d] != '0) begin
                for (int k = 0; k < N; k++) if (o_ack[d][k]) obs_ack_ch[d] = k;
                obs_ack_c[d] = cyc;
                req[d] = req[d] & ~o_ack[d];
                if (d == 0) begin
                    ackq.push_back(obs_ack_ch[0]);
                    ackc.push_back(cyc);
                end
            end
            if (o_mread[d]) begin
                obs_strobe_c[d] = cyc;
                mem_pend[d]     = 1;
                mem_due[d]      = cyc + lat[d];
                mem_val[d]      = memf(o_maddr[d]);
            end
        end

        // Drive inputs for this cycle
        if (rnd_mode) begin
            for (int k = 0; k < N; k++) addr[k] = $urandom;
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < N; k++)
                    if (!req[d][k] && $urandom_range(3) == 0) req[d][k] = 1'b1;
            frame = ($urandom_range(15) == 0);
            clear = N'($urandom & $urandom & $urandom);
        end else begin
            frame = frame_s;
            clear = clear_s;
        end
        frame_s = 1'b0;
        clear_s = '0;
        prev_rst = rst;
        rst = rst_s;
        bus0.i_req = req[0];
        bus1.i_req = req[1];
        for (int k = 0; k < N; k++) begin
            bus0.i_addr[k*AW +: AW] = addr[k];
            bus1.i_addr[k*AW +: AW] = addr[k];
        end
        bus0.i_frameStart = frame;      bus1.i_frameStart = frame;
        bus0.i_clearUnderrun = clear;   bus1.i_clearUnderrun = clear;
        bus0.i_memData = (mem_pend[0] && cyc == mem_due[0]) ? mem_val[0] : DW'($urandom);
        bus1.i_memData = (mem_pend[1] && cyc == mem_due[1]) ? mem_val[1] : DW'($urandom);
        for (int d = 0; d < 2; d++) if (mem_pend[d] && cyc == mem_due[d]) mem_pend[d] = 0;

        if (prev_rst === 1'b1 && rst === 1'b0) begin
            #1;
            chk("rst ack d0", 64'(bus0.o_ack), 64'd0);
            chk("rst read d0", 64'(bus0.o_memRead), 64'd0);
            chk("rst addr d0", 64'(bus0.o_memAddr), 64'd0);
            chk("rst data d0", 64'(bus0.o_data), 64'd0);
            chk("rst under d0", 64'(bus0.o_underrun), 64'd0);
            chk("rst ack d1", 64'(bus1.o_ack), 64'd0);
            chk("rst addr d1", 64'(bus1.o_memAddr), 64'd0);
        end

        // Advance the model over the edge that closes this cycle
        if (!rst_s) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                set = '0;
                if (frame) set = req[d] & ~((busy_lo[d] <= cyc && cyc <= busy_hi[d]) ? (N'(1) << ch[d]) : '0);
                exp_under[d] = (exp_under[d] & ~clear) | set;
                if (!active[d] && cyc >= next_arb[d] && req[d] != '0) begin
                    g = first_from(req[d], ptr[d]);
                    active[d]   = 1;
                    ch[d]       = g;
                    strobe_c[d] = cyc + 1;
                    ack_c[d]    = cyc + 2 + lat[d];
                    busy_lo[d]  = cyc + 1;
                    busy_hi[d]  = cyc + 2 + lat[d];
                    next_arb[d] = cyc + 3 + lat[d];
                    exp_addr[d] = addr[g];
                    exp_data[d] = memf(addr[g]);
                    ptr[d]      = (g + 1) % N;
                end
            end
        end
    endtask

    initial begin
        req[0] = '0; req[1] = '0;
        for (int k = 0; k < N; k++) addr[k] = '0;
        frame = 0; frame_s = 0; clear = '0; clear_s = '0; rnd_mode = 0;
        rst = 1'b0; rst_s = 1'b0; prev_rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mem_pend[d] = 0; obs_ack_c[d] = 0; obs_ack_ch[d] = -1; obs_strobe_c[d] = 0;
        end
        bus0.i_req = '0; bus0.i_addr = '0; bus0.i_memData = '0; bus0.i_frameStart = 0; bus0.i_clearUnderrun = '0;
        bus1.i_req = '0; bus1.i_addr = '0; bus1.i_memData = '0; bus1.i_frameStart = 0; bus1.i_clearUnderrun = '0;
        model_reset();

        repeat (3) step();
        chk("reset memAddr d0", 64'(bus0.o_memAddr), 64'd0);
        chk("reset memAddr d1", 64'(bus1.o_memAddr), 64'd0);
        rst_s = 1'b1;
        step();

        // All channels requesting, served 0..7 at four-cycle spacing
        ackq.delete(); ackc.delete();
        req[0] = 8'hFF; req[1] = 8'hFF;
        repeat (60) step();
        chk("allreq count", 64'(ackq.size()), 64'd8);
        for (int i = 0; i < 8 && i < ackq.size(); i++) chk($sformatf("allreq order %0d", i), 64'(ackq[i]), 64'(i));
        for (int i = 1; i < 8 && i < ackc.size(); i++)
            chk($sformatf("allreq spacing %0d", i), 64'(ackc[i] - ackc[i-1]), 64'd4);

        // Single request, address 100
        addr[2] = 32'd100;
        req[0] = 8'h04; req[1] = 8'h04;
        t_raise = cyc + 1;
        repeat (12) step();
        chk("single strobe lat1", 64'(obs_strobe_c[0] - t_raise), 64'd1);
        chk("single ack lat1", 64'(obs_ack_c[0] - t_raise), 64'd3);
        chk("single ack ch", 64'(obs_ack_ch[0]), 64'd2);
        chk("single data lat1", 64'(bus0.o_data), 64'h3A5);
        chk("single strobe lat3", 64'(obs_strobe_c[1] - t_raise), 64'd1);
        chk("single ack lat3", 64'(obs_ack_c[1] - t_raise), 64'd5);
        chk("single data lat3", 64'(bus1.o_data), 64'h3A5);

        // Rotation from pointer 6 after serving channel 5
        req[0] = 8'h20; req[1] = 8'h20;
        repeat (12) step();
        ackq.delete();
        req[0] = 8'h21; req[1] = 8'h21;
        repeat (16) step();
        chk("rotate count", 64'(ackq.size()), 64'd2);
        if (ackq.size() >= 2) begin
            chk("rotate first", 64'(ackq[0]), 64'd0);
            chk("rotate second", 64'(ackq[1]), 64'd5);
        end

        // Underrun while channel 1 is in flight, then clear collides with set
        req[0] = 8'h02; req[1] = 8'h02;
        step();
        req[0] |= 8'h08; req[1] |= 8'h08;
        step();
        frame_s = 1'b1;
        step();
        frame_s = 1'b1; clear_s = 8'h08;
        step();
        step();
        chk("underrun set d0", 64'(bus0.o_underrun), 64'h08);
        chk("underrun set d1", 64'(bus1.o_underrun), 64'h08);
        repeat (20) step();
        clear_s = 8'hFF;
        repeat (2) step();
        chk("underrun cleared d0", 64'(bus0.o_underrun), 64'h00);

        // Reset during WAIT abandons the transaction; pointer restarts at 0
        req[0] = 8'h90; req[1] = 8'h90;
        step();
        step();
        rst_s = 1'b0;
        repeat (3) step();
        ackq.delete();
        rst_s = 1'b1;
        req[0] = 8'h18; req[1] = 8'h18;
        repeat (20) step();
        chk("post-reset count", 64'(ackq.size()), 64'd2);
        if (ackq.size() >= 2) begin
            chk("post-reset first", 64'(ackq[0]), 64'd3);
            chk("post-reset second", 64'(ackq[1]), 64'd4);
        end

        // Randomized traffic, frames and clears
        rnd_mode = 1;
        repeat (800) step();
        rnd_mode = 0;
        req[0] = '0; req[1] = '0;
        repeat (20) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
